// File: rtl/config_sequencer_if.sv
// Command/memory/readback bus between the configuration sequencer
// (master) and the bitstream memory plus shift engine (slave).
interface config_sequencer_if #(
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH     = 32
);
    logic                      mem_rd_en;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [3:0]                cmd_opcode;
    logic                      cmd_bit;
    logic                      rb_valid;
    logic                      rb_bit;

    modport master (
        output mem_rd_en, mem_addr, cmd_valid, cmd_opcode, cmd_bit,
        input  mem_rdata, cmd_ready, rb_valid, rb_bit
    );

    modport slave (
        input  mem_rd_en, mem_addr, cmd_valid, cmd_opcode, cmd_bit,
        output mem_rdata, cmd_ready, rb_valid, rb_bit
    );
endinterface

// File: rtl/config_sequencer.sv
// Configuration sequencer: issues RESET, streams a bitstream from memory
// as CONFIGIN commands (LSB first), then optionally reads the chain back
// with CONFIGOUT and counts readback mismatches.
// DATA_WIDTH is expected to be a power of two.
module config_sequencer #(
    parameter int CONFIG_REG_WIDTH = 5164,
    parameter int MEM_ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH       = 32
) (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESETN,
    input  logic                start,
    input  logic                abort,
    input  logic [15:0]         nbits,
    input  logic                verify_en,
    input  logic                superpix_sel,
    config_sequencer_if.master  bus,
    output logic                busy,
    output logic                done,
    output logic [15:0]         mismatch_count,
    output logic                aborted
);

    localparam int IDX_W = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_RESET     = 4'b0001;
    localparam logic [3:0] OP_CONFIGIN  = 4'b0010;
    localparam logic [3:0] OP_CONFIGOUT = 4'b0100;

    typedef enum logic [3:0] {
        IDLE, RESET_CMD, FETCH, FETCH_WAIT, SHIFT,
        RB_FETCH, RB_FETCH_WAIT, RB_CMD, RB_WAIT, FINISH
    } state_t;

    state_t                  state;
    logic [15:0]             nbits_q;
    logic [15:0]             bit_index;
    logic                    verify_q;
    logic [DATA_WIDTH-1:0]   word;

    // Helpers describing the bit after the current one.
    logic [15:0]               next_index;
    logic                      last_bit;
    logic                      word_end;
    logic                      handshake;
    logic                      len_bad;
    logic [MEM_ADDR_WIDTH-1:0] next_addr;

    assign next_index = bit_index + 16'd1;
    assign last_bit   = (next_index == nbits_q);
    assign word_end   = (next_index[IDX_W-1:0] == '0);
    assign handshake  = bus.cmd_valid && bus.cmd_ready;
    assign len_bad    = (nbits == 16'd0) || (int'(nbits) > CONFIG_REG_WIDTH);
    assign next_addr  = MEM_ADDR_WIDTH'(next_index >> IDX_W);

    // Sequencer FSM; all outputs are registered and updated on the
    // transition into the state that owns them.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state          <= IDLE;
            nbits_q        <= '0;
            bit_index      <= '0;
            verify_q       <= 1'b0;
            word           <= '0;
            bus.mem_rd_en  <= 1'b0;
            bus.mem_addr   <= '0;
            bus.cmd_valid  <= 1'b0;
            bus.cmd_opcode <= '0;
            bus.cmd_bit    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mismatch_count <= '0;
            aborted        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the pre-edge register values; the later assignment of a signal
            // in the same branch wins.
            done <= 1'b0;
            if (state != IDLE && abort) begin
                state         <= IDLE;
                busy          <= 1'b0;
                bus.cmd_valid <= 1'b0;
                bus.mem_rd_en <= 1'b0;
                aborted       <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            nbits_q        <= nbits;
                            verify_q       <= verify_en;
                            mismatch_count <= '0;
                            bit_index      <= '0;
                            busy           <= 1'b1;
                            if (len_bad) begin
                                aborted <= 1'b1;
                                state   <= FINISH;
                            end else begin
                                aborted        <= 1'b0;
                                bus.cmd_valid  <= 1'b1;
                                bus.cmd_opcode <= OP_RESET;
                                bus.cmd_bit    <= superpix_sel;
                                state          <= RESET_CMD;
                            end
                        end
                    end
                    RESET_CMD: begin
                        if (handshake) begin
                            bus.cmd_valid <= 1'b0;
                            bus.mem_rd_en <= 1'b1;
                            bus.mem_addr  <= '0;
                            state         <= FETCH;
                        end
                    end
                    FETCH: begin
                        bus.mem_rd_en <= 1'b0;
                        state         <= FETCH_WAIT;
                    end
                    FETCH_WAIT: begin
                        word           <= bus.mem_rdata;
                        bus.cmd_valid  <= 1'b1;
                        bus.cmd_opcode <= OP_CONFIGIN;
                        bus.cmd_bit    <= bus.mem_rdata[bit_index[IDX_W-1:0]];
                        state          <= SHIFT;
                    end
                    SHIFT: begin
                        if (handshake) begin
                            if (last_bit) begin
                                bus.cmd_valid <= 1'b0;
                                if (verify_q) begin
                                    bit_index     <= '0;
                                    bus.mem_rd_en <= 1'b1;
                                    bus.mem_addr  <= '0;
                                    state         <= RB_FETCH;
                                end else begin
                                    bit_index <= next_index;
                                    done      <= 1'b1;
                                    state     <= FINISH;
                                end
                            end else if (word_end) begin
                                bit_index     <= next_index;
                                bus.cmd_valid <= 1'b0;
                                bus.mem_rd_en <= 1'b1;
                                bus.mem_addr  <= next_addr;
                                state         <= FETCH;
                            end else begin
                                bit_index   <= next_index;
                                bus.cmd_bit <= word[next_index[IDX_W-1:0]];
                            end
                        end
                    end
                    RB_FETCH: begin
                        bus.mem_rd_en <= 1'b0;
                        state         <= RB_FETCH_WAIT;
                    end
                    RB_FETCH_WAIT: begin
                        word           <= bus.mem_rdata;
                        bus.cmd_valid  <= 1'b1;
                        bus.cmd_opcode <= OP_CONFIGOUT;
                        bus.cmd_bit    <= 1'b0;
                        state          <= RB_CMD;
                    end
                    RB_CMD: begin
                        if (handshake) begin
                            bus.cmd_valid <= 1'b0;
                            state         <= RB_WAIT;
                        end
                    end
                    RB_WAIT: begin
                        if (bus.rb_valid) begin
                            if (bus.rb_bit != word[bit_index[IDX_W-1:0]] &&
                                mismatch_count != 16'hFFFF) begin
                                mismatch_count <= mismatch_count + 16'd1;
                            end
                            bit_index <= next_index;
                            if (last_bit) begin
                                done  <= 1'b1;
                                state <= FINISH;
                            end else if (word_end) begin
                                bus.mem_rd_en <= 1'b1;
                                bus.mem_addr  <= next_addr;
                                state         <= RB_FETCH;
                            end else begin
                                bus.cmd_valid <= 1'b1;
                                state         <= RB_CMD;
                            end
                        end
                    end
                    FINISH: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy          <= 1'b0;
                        bus.cmd_valid <= 1'b0;
                        bus.mem_rd_en <= 1'b0;
                        state         <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_config_sequencer.sv
// Self-checking bench for config_sequencer: a memory model, a randomised
// command/readback engine and a list-level model of the expected command
// stream, memory reads and mismatch count.
module tb_config_sequencer;

    localparam int BUDGET = 4000;
    localparam logic [3:0] OP_RS = 4'b0001;
    localparam logic [3:0] OP_CI = 4'b0010;
    localparam logic [3:0] OP_CO = 4'b0100;

    logic        S_AXI_ACLK;
    logic        S_AXI_ARESETN;
    logic        start;
    logic        abort;
    logic [15:0] nbits;
    logic        verify_en;
    logic        superpix_sel;
    logic        busy;
    logic        done;
    logic [15:0] mismatch_count;
    logic        aborted;

    config_sequencer_if #(.MEM_ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    config_sequencer #(
        .CONFIG_REG_WIDTH(5164),
        .MEM_ADDR_WIDTH  (8),
        .DATA_WIDTH      (32)
    ) dut (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .start         (start),
        .abort         (abort),
        .nbits         (nbits),
        .verify_en     (verify_en),
        .superpix_sel  (superpix_sel),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .mismatch_count(mismatch_count),
        .aborted       (aborted)
    );

    int errors = 0;
    int checks = 0;

    // Stimulus knobs (written by the main sequence, read by the engine).
    logic [31:0] mem [0:255];
    bit          flip [0:1023];
    int          ready_mode  = 0;  // 0: always ready, 1: random, 2: never
    bit          spurious_en = 0;

    // Engine observations (written by the engine only).
    logic [4:0]  cmd_log [$];
    int          rd_log [$];
    int          valid_cycles = 0;
    int          stab_err = 0;
    int          rb_timer = 0;
    int          rb_k = 0;
    int          out_idx = 0;
    bit          prev_stall = 0;
    bit          prev_abort = 0;
    logic [4:0]  prev_cmd = '0;
    logic [31:0] rdata_q = '0;

    initial begin
        S_AXI_ACLK = 1'b0;
        forever #5 S_AXI_ACLK = ~S_AXI_ACLK;
    end

    // Synchronous-read memory: data appears the cycle after mem_rd_en.
    always @(posedge S_AXI_ACLK) begin
        if (bus.mem_rd_en) rdata_q <= mem[bus.mem_addr];
    end
    assign bus.mem_rdata = rdata_q;

    function automatic logic membit(input int i);
        logic [31:0] w;
        w = mem[i / 32];
        return w[i % 32];
    endfunction

    function automatic int count_op(input int base, input logic [3:0] op);
        int c = 0;
        for (int i = base; i < cmd_log.size(); i++) begin
            if (cmd_log[i][4:1] == op) c++;
        end
        return c;
    endfunction

    // Downstream engine: drives ready/readback on the falling edge and logs
    // the handshakes that the following rising edge will complete.
    initial begin : engine
        bus.cmd_ready = 1'b0;
        bus.rb_valid  = 1'b0;
        bus.rb_bit    = 1'b0;
        forever begin
            @(negedge S_AXI_ACLK);
            if (!S_AXI_ARESETN) begin
                bus.cmd_ready = 1'b0;
                bus.rb_valid  = 1'b0;
                bus.rb_bit    = 1'b0;
                rb_timer      = 0;
                prev_stall    = 0;
            end else begin
                if (prev_stall && !prev_abort) begin
                    if (!(bus.cmd_valid && {bus.cmd_opcode, bus.cmd_bit} == prev_cmd))
                        stab_err++;
                end
                case (ready_mode)
                    0:       bus.cmd_ready = 1'b1;
                    1:       bus.cmd_ready = 1'($urandom_range(0, 1));
                    default: bus.cmd_ready = 1'b0;
                endcase
                bus.rb_valid = 1'b0;
                if (rb_timer > 0) begin
                    rb_timer--;
                    if (rb_timer == 0) begin
                        bus.rb_valid = 1'b1;
                        bus.rb_bit   = membit(rb_k) ^ flip[rb_k];
                    end
                end else if (spurious_en && $urandom_range(0, 5) == 0) begin
                    bus.rb_valid = 1'b1;
                    bus.rb_bit   = 1'($urandom_range(0, 1));
                end
                if (bus.mem_rd_en) rd_log.push_back(int'(bus.mem_addr));
                if (bus.cmd_valid) valid_cycles++;
                if (bus.cmd_valid && bus.cmd_ready) begin
                    cmd_log.push_back({bus.cmd_opcode, bus.cmd_bit});
                    if (bus.cmd_opcode == OP_RS) out_idx = 0;
                    if (bus.cmd_opcode == OP_CO) begin
                        rb_k     = out_idx;
                        out_idx++;
                        rb_timer = $urandom_range(1, 3);
                    end
                end
                prev_stall = bus.cmd_valid && !bus.cmd_ready;
                prev_cmd   = {bus.cmd_opcode, bus.cmd_bit};
                prev_abort = abort;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [15:0] n, input logic v, input logic sp);
        @(posedge S_AXI_ACLK); #1;
        nbits = n; verify_en = v; superpix_sel = sp; start = 1'b1;
        @(posedge S_AXI_ACLK); #1;
        start = 1'b0;
    endtask

    task automatic run(input logic [15:0] n, input logic v, input logic sp,
                       output int ndone, output int bcyc);
        pulse_start(n, v, sp);
        ndone = 0;
        bcyc  = 0;
        do begin
            @(negedge S_AXI_ACLK);
            if (done) ndone++;
            if (busy) bcyc++;
        end while (busy && bcyc < BUDGET);
        check("run_timeout", {31'b0, busy}, 32'd0);
    endtask

    // Full run checked against the list-level model of the specification.
    task automatic do_run(input string tag, input logic [15:0] n, input logic v,
                          input logic sp, input int mode);
        logic [4:0] exp_c [$];
        int exp_r [$];
        int cb, rb, ndone, bcyc, words, nflip, diff;
        ready_mode  = mode;
        spurious_en = !v;
        cb = cmd_log.size();
        rb = rd_log.size();
        run(n, v, sp, ndone, bcyc);
        exp_c.push_back({OP_RS, sp});
        for (int i = 0; i < int'(n); i++) exp_c.push_back({OP_CI, membit(i)});
        words = (int'(n) + 31) / 32;
        for (int w = 0; w < words; w++) exp_r.push_back(w);
        nflip = 0;
        if (v) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_c.push_back({OP_CO, 1'b0});
                if (flip[i]) nflip++;
            end
            for (int w = 0; w < words; w++) exp_r.push_back(w);
        end
        check({tag, "_ncmd"}, cmd_log.size() - cb, exp_c.size());
        diff = -1;
        for (int i = 0; i < exp_c.size(); i++) begin
            if (diff < 0 && (cb + i >= cmd_log.size() || cmd_log[cb + i] !== exp_c[i])) diff = i;
        end
        check({tag, "_cmd_first_diff"}, diff, -1);
        check({tag, "_nreads"}, rd_log.size() - rb, exp_r.size());
        diff = -1;
        for (int i = 0; i < exp_r.size(); i++) begin
            if (diff < 0 && (rb + i >= rd_log.size() || rd_log[rb + i] != exp_r[i])) diff = i;
        end
        check({tag, "_read_first_diff"}, diff, -1);
        check({tag, "_done_pulses"}, ndone, 1);
        check({tag, "_mismatch"}, {16'b0, mismatch_count}, nflip);
        check({tag, "_aborted"}, {31'b0, aborted}, 0);
        ready_mode  = 0;
        spurious_en = 0;
    endtask

    task automatic bad_len(input string tag, input logic [15:0] n);
        int cb, vc, ndone, bcyc;
        cb = cmd_log.size();
        vc = valid_cycles;
        run(n, 1'b0, 1'b0, ndone, bcyc);
        check({tag, "_ncmd"}, cmd_log.size() - cb, 0);
        check({tag, "_valid_cycles"}, valid_cycles - vc, 0);
        check({tag, "_aborted"}, {31'b0, aborted}, 1);
        check({tag, "_done_pulses"}, ndone, 0);
        check({tag, "_busy_le2"}, {31'b0, bcyc <= 2}, 1);
    endtask

    task automatic clear_flips();
        for (int i = 0; i < 1024; i++) flip[i] = 1'b0;
    endtask

    initial begin : main
        int cb, cnt, ndone;
        logic [15:0] n;
        logic v;
        start = 1'b0; abort = 1'b0; nbits = '0; verify_en = 1'b0; superpix_sel = 1'b0;
        S_AXI_ARESETN = 1'b0;
        clear_flips();
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        // Reset state.
        repeat (3) @(posedge S_AXI_ACLK);
        @(negedge S_AXI_ACLK);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_cmd_valid", {31'b0, bus.cmd_valid}, 0);
        check("rst_opcode", {28'b0, bus.cmd_opcode}, 0);
        check("rst_mem_rd_en", {31'b0, bus.mem_rd_en}, 0);
        check("rst_mismatch", {16'b0, mismatch_count}, 0);
        check("rst_aborted", {31'b0, aborted}, 0);
        @(posedge S_AXI_ACLK); #1;
        S_AXI_ARESETN = 1'b1;

        // Basic 8-bit load from 0xA5.
        mem[0] = 32'h0000_00A5;
        do_run("a5", 16'd8, 1'b0, 1'b0, 0);

        // 40 bits across two words with a stalling engine.
        mem[0] = $urandom;
        mem[1] = $urandom;
        do_run("n40_stall", 16'd40, 1'b0, 1'b1, 1);
        check("stall_payload_stable", stab_err, 0);

        // Readback with bit 3 flipped by the engine.
        clear_flips();
        flip[3] = 1'b1;
        do_run("verify_flip3", 16'd8, 1'b1, 1'b0, 1);

        // Random lengths, verify modes, flips and back-pressure.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++) mem[i] = $urandom;
            for (int i = 0; i < 1024; i++) flip[i] = ($urandom_range(0, 7) == 0);
            n = 16'($urandom_range(1, 100));
            v = 1'($urandom_range(0, 1));
            do_run($sformatf("rand%0d", r), n, v, 1'($urandom_range(0, 1)), 1);
        end
        check("rand_payload_stable", stab_err, 0);

        // Abort while shifting bit 5, engine stalled.
        clear_flips();
        ready_mode = 0;
        cb = cmd_log.size();
        ndone = 0;
        pulse_start(16'd20, 1'b0, 1'b0);
        cnt = 0;
        while (count_op(cb, OP_CI) < 5 && cnt < 500) begin
            @(negedge S_AXI_ACLK);
            if (done) ndone++;
            cnt++;
        end
        check("abort_reached_bit5", {31'b0, count_op(cb, OP_CI) >= 5}, 1);
        @(posedge S_AXI_ACLK); #1;
        ready_mode = 2;
        abort      = 1'b1;
        @(posedge S_AXI_ACLK); #1;
        abort = 1'b0;
        @(negedge S_AXI_ACLK);
        if (done) ndone++;
        check("abort_cmd_valid", {31'b0, bus.cmd_valid}, 0);
        check("abort_aborted", {31'b0, aborted}, 1);
        check("abort_busy", {31'b0, busy}, 0);
        repeat (3) begin
            @(negedge S_AXI_ACLK);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_configin_count", count_op(cb, OP_CI), 5);
        ready_mode = 0;

        // Abort and start together in IDLE: start is dropped.
        @(posedge S_AXI_ACLK); #1;
        nbits = 16'd8; start = 1'b1; abort = 1'b1;
        @(posedge S_AXI_ACLK); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge S_AXI_ACLK);
        check("abort_start_busy", {31'b0, busy}, 0);
        check("abort_start_aborted_kept", {31'b0, aborted}, 1);

        // A later start clears aborted.
        mem[0] = 32'h0000_00A5;
        do_run("after_abort", 16'd8, 1'b0, 1'b1, 0);

        // Invalid lengths.
        bad_len("nbits0", 16'd0);
        bad_len("nbits5165", 16'd5165);

        // Reset asserted while waiting for readback.
        clear_flips();
        ready_mode = 0;
        cb = cmd_log.size();
        pulse_start(16'd8, 1'b1, 1'b1);
        cnt = 0;
        while (count_op(cb, OP_CO) < 1 && cnt < 500) begin
            @(negedge S_AXI_ACLK);
            cnt++;
        end
        check("rbwait_reached", {31'b0, count_op(cb, OP_CO) >= 1}, 1);
        @(posedge S_AXI_ACLK); #1;
        check("rbwait_busy_before_rst", {31'b0, busy}, 1);
        S_AXI_ARESETN = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy}, 0);
        check("arst_cmd_valid", {31'b0, bus.cmd_valid}, 0);
        check("arst_opcode", {28'b0, bus.cmd_opcode}, 0);
        check("arst_cmd_bit", {31'b0, bus.cmd_bit}, 0);
        check("arst_mem_rd_en", {31'b0, bus.mem_rd_en}, 0);
        check("arst_mem_addr", {24'b0, bus.mem_addr}, 0);
        check("arst_done", {31'b0, done}, 0);
        check("arst_aborted", {31'b0, aborted}, 0);
        repeat (2) @(posedge S_AXI_ACLK);
        #1;
        S_AXI_ARESETN = 1'b1;
        mem[0] = 32'h0000_00A5;
        do_run("a5_after_rst", 16'd8, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/config_sequencer.md
CONFIG_SEQUENCER -- requirements
Module: config_sequencer

Interface
REQ-001 Parameter CONFIG_REG_WIDTH, default 5164: maximum chain length in bits.
REQ-002 Parameter MEM_ADDR_WIDTH, default 8: word address width of the bitstream memory.
REQ-003 Parameter DATA_WIDTH, default 32: memory word width.
REQ-004 S_AXI_ACLK  in  1  system clock; every flop is clocked on its rising edge.
REQ-005 S_AXI_ARESETN  in  1  reset; asynchronous assertion, active-low.
REQ-006 start  in  1  single-cycle run request.
REQ-007 abort  in  1  stops the run and returns to IDLE.
REQ-008 nbits  in  16  number of chain bits for this run; latched on start.
REQ-009 verify_en  in  1  enables a readback pass; latched on start.
REQ-010 superpix_sel  in  1  superpixel select sent with the RESET command; latched on start.
REQ-011 mem_rd_en  out  1  memory read strobe.
REQ-012 mem_addr  out  MEM_ADDR_WIDTH  memory word address.
REQ-013 mem_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
REQ-014 cmd_valid  out  1  command valid.
REQ-015 cmd_ready  in  1  downstream engine accepts the command.
REQ-016 cmd_opcode  out  4  command code: 0001 RESET, 0010 CONFIGIN, 0100 CONFIGOUT.
REQ-017 cmd_bit  out  1  serial data bit for CONFIGIN; superpix_sel for RESET; 0 otherwise.
REQ-018 rb_valid  in  1  readback bit strobe from the engine.
REQ-019 rb_bit  in  1  readback bit.
REQ-020 busy  out  1  high whenever the state is not IDLE.
REQ-021 done  out  1  1-cycle pulse on normal completion.
REQ-022 mismatch_count  out  16  readback mismatch count; saturates at 0xFFFF.
REQ-023 aborted  out  1  sticky; cleared by the next accepted start.

Function
REQ-024 The state machine SHALL have the states IDLE, RESET_CMD, FETCH, FETCH_WAIT, SHIFT, RB_FETCH, RB_FETCH_WAIT, RB_CMD, RB_WAIT and FINISH.
REQ-025 In IDLE, start SHALL latch nbits, verify_en and superpix_sel, clear mismatch_count and aborted, zero the bit index and move to RESET_CMD; start SHALL be ignored while busy.
REQ-026 nbits equal to 0 or greater than CONFIG_REG_WIDTH SHALL move IDLE->FINISH directly, issue no commands and set aborted.
REQ-027 RESET_CMD SHALL present opcode 0001 with cmd_bit = superpix_sel, then move to FETCH on handshake.
REQ-028 A command handshake SHALL occur on a cycle where cmd_valid and cmd_ready are both high; opcode and bit SHALL be held stable until that cycle; cmd_valid SHALL go low the cycle after acceptance unless the next command follows back-to-back.
REQ-029 FETCH SHALL assert mem_rd_en for 1 cycle with mem_addr = bit_index / DATA_WIDTH; FETCH_WAIT SHALL capture mem_rdata into a word register on the following cycle.
REQ-030 SHIFT SHALL issue one CONFIGIN per bit, sending the LSB first: cmd_bit = word[bit_index mod DATA_WIDTH].
REQ-031 After each SHIFT handshake, bit_index SHALL increment; SHIFT SHALL go to FETCH at a word boundary.
REQ-032 After the last SHIFT handshake (bit_index reaching nbits), SHIFT SHALL go to RB_FETCH if verify_en is set, otherwise to FINISH.
REQ-033 The readback pass SHALL reset bit_index to 0 and refetch words the same way (RB_FETCH, RB_FETCH_WAIT).
REQ-034 RB_CMD SHALL issue opcode 0100 for each bit.
REQ-035 RB_WAIT SHALL hold until rb_valid, then compare rb_bit with the expected bit and increment mismatch_count on inequality.
REQ-036 rb_valid SHALL be ignored outside RB_WAIT.
REQ-037 FINISH SHALL pulse done for 1 cycle (not on abort or invalid-length exit) and return to IDLE.
REQ-038 abort SHALL take priority in any non-IDLE state: the next state is IDLE, cmd_valid drops immediately (even mid-handshake), aborted is set and done is not pulsed.
REQ-039 abort and start in the same cycle while in IDLE: abort wins and start is dropped.
REQ-040 bit_index SHALL be 16 bits and never exceed nbits.
REQ-041 mem_addr SHALL never exceed (nbits-1)/DATA_WIDTH.

Reset
REQ-042 Asserting S_AXI_ARESETN low SHALL immediately force state IDLE, cmd_valid=0, cmd_opcode=0, cmd_bit=0, mem_rd_en=0, mem_addr=0, busy=0, done=0, mismatch_count=0, aborted=0, bit_index=0, even in the middle of a run.

Verification
REQ-043 mem[0]=0x0000_00A5, nbits=8, verify_en=0, cmd_ready=1 -> RESET, then CONFIGIN bits 1,0,1,0,0,1,0,1, then done pulse; 1 memory read.
REQ-044 nbits=40, cmd_ready toggling randomly -> 40 CONFIGIN commands with stable payload while stalled; reads at addr 0 and 1 only.
REQ-045 verify_en=1, nbits=8, engine echoes bits except it flips bit 3 -> 8 CONFIGOUT commands, mismatch_count=1, done pulses.
REQ-046 abort during SHIFT at bit 5 -> cmd_valid low the next cycle, aborted=1, no done; a later start clears aborted.
REQ-047 nbits=0 and nbits=5165 -> no cmd_valid, aborted=1, busy for ≤2 cycles.
REQ-048 ARESETN asserted during RB_WAIT -> all outputs at reset values asynchronously; a new run after release behaves as in REQ-043.
